// File: rtl/vga_text_sequencer.sv
// Text console: places glyphs at the cursor and sequences clear/scroll on the char/colour RAM write port.
// Latency: glyph 3 cycles, clear 2*ROWS*COLS, scroll 4*(ROWS-1)*COLS+2*COLS; cursor/colour writes 1 cycle.
// Backpressure: busy while sequencing; writes during busy are dropped and flagged. VGA_TEXT_AUTOSCROLL_EN scrolls on overflow.
module vga_text_sequencer #(
    parameter int         COLS        = 50,
    parameter int         ROWS        = 37,
    parameter logic [7:0] RESET_COLOR = 8'hF0
) (
    input  logic        clk_20MHz,
    input  logic        n_reset,
    input  logic [2:0]  reg_sel,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_we,
    input  logic        status_rd,
    output logic [7:0]  status,
    output logic        busy,
    output logic [5:0]  cur_x,
    output logic [5:0]  cur_y,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);
    typedef enum logic [3:0] {
        S_IDLE, S_PUT_C, S_PUT_A, S_ADV,
        S_RD_C, S_WR_C, S_RD_A, S_WR_A,
        S_FILL_C, S_FILL_A
    } state_t;

    localparam logic [5:0] LAST_X     = 6'(COLS - 1);
    localparam logic [5:0] LAST_Y     = 6'(ROWS - 1);
    localparam logic [5:0] SCR_LAST_Y = 6'(ROWS - 2);

    state_t     state_q, state_d;
    logic [5:0] x_q, x_d, y_q, y_d, col_q, col_d, row_q, row_d;
    logic [7:0] color_q, color_d, code_q, code_d;
    logic       dropped_q, dropped_d, clr_q, clr_d;
    logic [5:0] y_next, row_p1;
    logic       lf_scroll;

    assign row_p1 = row_q + 6'd1;
    assign busy   = (state_q != S_IDLE);
    assign status = {busy, dropped_q, 6'b0};
    assign cur_x  = x_q;
    assign cur_y  = y_q;

    // Next cursor row for a line feed or wrap past the last column.
    always_comb begin
        lf_scroll = 1'b0;
        y_next    = y_q + 6'd1;
        if (y_q == LAST_Y) begin
`ifdef VGA_TEXT_AUTOSCROLL_EN
            y_next    = y_q;
            lf_scroll = 1'b1;
`else
            y_next    = '0;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        row_d     = row_q;
        color_d   = color_q;
        code_d    = code_q;
        clr_d     = clr_q;
        dropped_d = dropped_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (status_rd) dropped_d = 1'b0;
        if (reg_we && state_q != S_IDLE) dropped_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (reg_we) begin
                    case (reg_sel)
                        3'd0: begin
                            if (reg_wdata == 8'h0D) begin
                                x_d = '0;
                            end else if (reg_wdata == 8'h0A) begin
                                x_d = '0;
                                y_d = y_next;
                                if (lf_scroll) begin
                                    state_d = S_RD_C;
                                    row_d   = '0;
                                    col_d   = '0;
                                end
                            end else if (reg_wdata == 8'h08) begin
                                if (x_q != 6'd0) x_d = x_q - 6'd1;
                            end else begin
                                code_d  = reg_wdata;
                                state_d = S_PUT_C;
                            end
                        end
                        3'd1: color_d = reg_wdata;
                        3'd2: x_d = (reg_wdata > 8'(COLS - 1)) ? LAST_X : reg_wdata[5:0];
                        3'd3: y_d = (reg_wdata > 8'(ROWS - 1)) ? LAST_Y : reg_wdata[5:0];
                        3'd4: begin
                            if (reg_wdata[0]) begin
                                state_d = S_FILL_C;
                                row_d   = '0;
                                col_d   = '0;
                                clr_d   = 1'b1;
                            end else if (reg_wdata[1]) begin
                                state_d = S_RD_C;
                                row_d   = '0;
                                col_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_PUT_C: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b0, y_q, x_q};
                ram_wdata = code_q;
                state_d   = S_PUT_A;
            end
            S_PUT_A: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b1, y_q, x_q};
                ram_wdata = color_q;
                state_d   = S_ADV;
            end
            S_ADV: begin
                state_d = S_IDLE;
                if (x_q == LAST_X) begin
                    x_d = '0;
                    y_d = y_next;
                    if (lf_scroll) begin
                        state_d = S_RD_C;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end else begin
                    x_d = x_q + 6'd1;
                end
            end
            // Row r+1 is read the cycle before it is written into row r.
            S_RD_C: begin
                ram_addr = {1'b0, row_p1, col_q};
                state_d  = S_WR_C;
            end
            S_WR_C: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b0, row_q, col_q};
                ram_wdata = ram_rdata;
                state_d   = S_RD_A;
            end
            S_RD_A: begin
                ram_addr = {1'b1, row_p1, col_q};
                state_d  = S_WR_A;
            end
            S_WR_A: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b1, row_q, col_q};
                ram_wdata = ram_rdata;
                state_d   = S_RD_C;
                if (col_q == LAST_X) begin
                    col_d = '0;
                    if (row_q == SCR_LAST_Y) begin
                        row_d   = LAST_Y;
                        state_d = S_FILL_C;
                    end else begin
                        row_d = row_p1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                end
            end
            S_FILL_C: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b0, row_q, col_q};
                ram_wdata = 8'h20;
                state_d   = S_FILL_A;
            end
            S_FILL_A: begin
                ram_we    = 1'b1;
                ram_addr  = {1'b1, row_q, col_q};
                ram_wdata = color_q;
                state_d   = S_FILL_C;
                if (col_q == LAST_X) begin
                    col_d = '0;
                    if (row_q == LAST_Y) begin
                        state_d = S_IDLE;
                        clr_d   = 1'b0;
                        if (clr_q) begin
                            x_d = '0;
                            y_d = '0;
                        end
                    end else begin
                        row_d = row_p1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_20MHz) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            color_q   <= RESET_COLOR;
            code_q    <= '0;
            clr_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
            row_q     <= row_d;
            color_q   <= color_d;
            code_q    <= code_d;
            clr_q     <= clr_d;
            dropped_q <= dropped_d;
        end
    end
endmodule
